// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with a two-flop column synchroniser and press/release
// debouncing; presents a stable key code, a held flag and a one-cycle accept strobe.
module keypad_scan_debounce #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] key,
   output logic       pressed,
   output logic       key_valid
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   // Indexed by {row, column}; row r is the zero bit of row_n.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hF, 4'h0, 4'hE, 4'hD
   };

   typedef enum logic [1:0] {SCAN, PDEB, HELD, RDEB} state_t;

   state_t           state, state_nx;
   logic [3:0]       sync1, cs;
   logic [DIV_W-1:0] div, div_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       row_nx, row_rot, cand, cand_nx, cpat, cpat_nx, key_nx;
   logic             pressed_nx, key_valid_nx;
   logic [1:0]       row_idx, col_idx;

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 4'b1111;
         cs    <= 4'b1111;
      end else begin
         sync1 <= col_n;
         cs    <= sync1;
      end
   end

   always_comb begin
      row_idx = 2'd0;
      col_idx = 2'd0;
      // Descending loops: the lowest-index zero is assigned last and wins.
      for (int i = 3; i >= 0; i--) begin
         if (!row_n[i]) row_idx = 2'(i);
         if (!cs[i])    col_idx = 2'(i);
      end
   end

   assign row_rot = {row_n[2:0], row_n[3]};

   always_comb begin
      // NOTE: every next-value signal gets a hold default first, so no branch can infer a latch.
      state_nx     = state;
      div_nx       = div;
      cnt_nx       = cnt;
      row_nx       = row_n;
      cand_nx      = cand;
      cpat_nx      = cpat;
      key_nx       = key;
      pressed_nx   = pressed;
      key_valid_nx = 1'b0;
      unique case (state)
         SCAN: begin
            if (div == DIV_LAST) begin
               div_nx = '0;
               if (cs != 4'b1111) begin
                  state_nx = PDEB;
                  cand_nx  = KEY_MAP[{row_idx, col_idx}];
                  cpat_nx  = cs;
                  cnt_nx   = '0;
               end else begin
                  row_nx = row_rot;
               end
            end else begin
               div_nx = div + 1'b1;
            end
         end
         PDEB: begin
            if (cs != cpat) begin
               state_nx = SCAN;
               cnt_nx   = '0;
               div_nx   = '0;
               row_nx   = row_rot;
            end else if (cnt == CNT_LAST) begin
               state_nx     = HELD;
               cnt_nx       = '0;
               key_nx       = cand;
               pressed_nx   = 1'b1;
               key_valid_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         HELD: begin
            if (cs == 4'b1111) begin
               state_nx = RDEB;
               cnt_nx   = '0;
            end
         end
         RDEB: begin
            // A column dropping low again is release bounce, not a new key.
            if (cs != 4'b1111) begin
               state_nx = HELD;
            end else if (cnt == CNT_LAST) begin
               state_nx   = SCAN;
               cnt_nx     = '0;
               div_nx     = '0;
               row_nx     = row_rot;
               pressed_nx = 1'b0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         div       <= '0;
         cnt       <= '0;
         row_n     <= 4'b1110;
         cand      <= 4'h0;
         cpat      <= 4'b1111;
         key       <= 4'h0;
         pressed   <= 1'b0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         div       <= div_nx;
         cnt       <= cnt_nx;
         row_n     <= row_nx;
         cand      <= cand_nx;
         cpat      <= cpat_nx;
         key       <= key_nx;
         pressed   <= pressed_nx;
         key_valid <= key_valid_nx;
      end
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a keypad model answers the DUT's row drive, and
// expected codes/latencies come from the key map and timing rules of the block.
module tb_keypad_scan_debounce;
   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;
   localparam int PRESS_LAT    = SCAN_DIV + DEBOUNCE_CNT;  // row active -> key_valid
   localparam int REL_LAT      = DEBOUNCE_CNT + 3;         // release -> pressed low

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key;
   logic       pressed;
   logic       key_valid;

   logic [15:0] down = '0;     // bit r*4+c: key at row r, column c held down
   logic        glitch = 1'b0; // forces every column open for the current cycle
   logic [3:0]  exp_key = 4'h0;
   int          checks = 0;
   int          errors = 0;

   logic [3:0] kmap [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hF, 4'h0, 4'hE, 4'hD
   };

   keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
      .clk       (clk),
      .rst       (rst),
      .col_n     (col_n),
      .row_n     (row_n),
      .key       (key),
      .pressed   (pressed),
      .key_valid (key_valid)
   );

   always #5 clk = ~clk;

   // Passive matrix: a held key pulls its column low only while its row is driven.
   always_comb begin
      col_n = 4'b1111;
      if (!glitch)
         for (int r = 0; r < 4; r++)
            if (!row_n[r])
               for (int c = 0; c < 4; c++)
                  if (down[r*4+c]) col_n[c] = 1'b0;
   end

   function automatic logic [3:0] row_pat(input int r);
      logic [3:0] p;
      p = 4'b1111;
      p[r[1:0]] = 1'b0;
      return p;
   endfunction

   function automatic logic [3:0] exp_code(input int r, input logic [3:0] mask);
      for (int c = 0; c < 4; c++)
         if (mask[c]) return kmap[r*4+c];
      return 4'h0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_row_inactive(input int r);
      int n;
      n = 0;
      while (row_n == row_pat(r) && n < 4*SCAN_DIV) begin
         tick();
         n++;
      end
   endtask

   task automatic press_check(input int r, input logic [3:0] mask);
      int n;
      wait_row_inactive(r);
      down    = 16'(mask) << (4*r);
      exp_key = exp_code(r, mask);
      n = 0;
      while (row_n != row_pat(r) && n < 8*SCAN_DIV) begin
         check("scan_quiet", {pressed, key_valid}, 2'b00);
         tick();
         n++;
      end
      check("row_reached", row_n, row_pat(r));
      n = 0;
      while (key_valid !== 1'b1 && n < PRESS_LAT + 4) begin
         tick();
         n++;
      end
      check("press_latency", n, PRESS_LAT);
      check("press_key", key, exp_key);
      check("press_flag", pressed, 1'b1);
      check("press_row", row_n, row_pat(r));
      tick();
      check("kv_single", key_valid, 1'b0);
   endtask

   task automatic hold(input int r, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         check("hold", {key_valid, pressed, row_n, key}, {1'b0, 1'b1, row_pat(r), exp_key});
         tick();
      end
   endtask

   task automatic release_check(input int r);
      int n;
      down = '0;
      n = 0;
      while (pressed !== 1'b0 && n < REL_LAT + 6) begin
         check("release_kv", key_valid, 1'b0);
         tick();
         n++;
      end
      check("release_latency", n, REL_LAT);
      check("release_key", key, exp_key);
      for (int k = 0; k < 2*SCAN_DIV; k++) begin
         check("rescan_row", row_n, row_pat((r + 1 + k/SCAN_DIV) % 4));
         tick();
      end
   endtask

   // Key "A" held with a one-cycle open column every p cycles; p <= DEBOUNCE_CNT+1
   // never yields the capture cycle plus DEBOUNCE_CNT matching cycles.
   task automatic press_bounce(input int p);
      int  w;
      bit  seen0, left0;
      w = p * ((80 + p - 1) / p);
      wait_row_inactive(0);
      down  = 16'h0008;
      seen0 = 1'b0;
      left0 = 1'b0;
      for (int k = 0; k < w; k++) begin
         glitch = (k % p == p - 1);
         check("bounce_quiet", {pressed, key_valid}, 2'b00);
         if (row_n == row_pat(0)) seen0 = 1'b1;
         else if (seen0) left0 = 1'b1;
         tick();
      end
      glitch = 1'b0;
      down   = '0;
      for (int k = 0; k < DEBOUNCE_CNT + 4; k++) begin
         check("bounce_tail", {pressed, key_valid}, 2'b00);
         tick();
      end
      check("bounce_rescan", left0, 1'b1);
   endtask

   // Columns open for len cycles while held; len <= DEBOUNCE_CNT must not release.
   task automatic release_bounce(input int r, input int len);
      logic [15:0] saved;
      saved = down;
      down  = '0;
      for (int k = 0; k < len; k++) begin
         check("rel_bounce", {key_valid, pressed, row_n}, {1'b0, 1'b1, row_pat(r)});
         tick();
      end
      down = saved;
      hold(r, 2*DEBOUNCE_CNT);
   endtask

   initial begin
      int          order [16];
      int          r6, c6, pulses;
      logic [3:0]  hi, mask, got;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_row", row_n, 4'b1110);
      check("reset_out", {key, pressed, key_valid}, 6'h00);
      rst = 1'b0;

      // Idle scan: each row held SCAN_DIV cycles, rotating 1110 -> 1101 -> 1011 -> 0111.
      for (int k = 0; k < 40; k++) begin
         check("idle_row", row_n, row_pat((k / SCAN_DIV) % 4));
         check("idle_out", {key, pressed, key_valid}, 6'h00);
         tick();
      end

      // Key "8": row 2, column 1, held 100 cycles.
      press_check(2, 4'b0010);
      hold(2, 100);
      release_check(2);

      // Press bounce on "A", at the spec'd period and at the acceptance boundary.
      press_bounce(5);
      press_bounce(DEBOUNCE_CNT + 1);
      press_check(0, 4'b1000);
      hold(0, 10);
      release_check(0);

      // Release bounce on "0".
      press_check(3, 4'b0010);
      hold(3, 10);
      release_bounce(3, 3);
      release_bounce(3, $urandom_range(1, DEBOUNCE_CNT - 1));
      release_bounce(3, DEBOUNCE_CNT);
      release_check(3);

      // Two keys on row 1: column 1 wins over column 2.
      press_check(1, 4'b0110);
      hold(1, 5);
      release_check(1);

      // All sixteen keys in random order, with random extra columns above the winner.
      for (int i = 0; i < 16; i++) order[i] = i;
      for (int i = 15; i > 0; i--) begin
         int j, t;
         j = $urandom_range(0, i);
         t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int i = 0; i < 16; i++) begin
         hi   = 4'hF << (order[i] % 4 + 1);
         mask = (4'b0001 << (order[i] % 4)) | (4'($urandom_range(0, 15)) & hi);
         press_check(order[i] / 4, mask);
         hold(order[i] / 4, $urandom_range(5, 40));
         release_check(order[i] / 4);
      end

      // Asynchronous reset while HELD; key stays down through reset.
      r6 = $urandom_range(0, 3);
      c6 = $urandom_range(0, 3);
      press_check(r6, 4'b0001 << c6);
      hold(r6, 10);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_row", row_n, 4'b1110);
      check("async_rst_out", {key, pressed, key_valid}, 6'h00);
      @(negedge clk);
      tick();
      rst    = 1'b0;
      pulses = 0;
      got    = 4'h0;
      for (int k = 0; k < 16*SCAN_DIV; k++) begin
         if (key_valid === 1'b1) begin
            pulses++;
            got = key;
         end
         tick();
      end
      check("rst_redetect_pulses", pulses, 1);
      check("rst_redetect_key", got, exp_key);
      check("rst_redetect_flag", pressed, 1'b1);
      release_check(r6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
